// File: rtl/instr_encoder.sv
// Packs mnemonic/operand beats into 32-bit instruction words, buffers them in a
// small FIFO and streams them to consecutive instruction-memory addresses.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AW        = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_mnem,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  input  logic          in_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  input  logic          imem_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   word_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] BASE     = AW'(BASE_ADDR);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wc_q, wc_d;
  logic          err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_ok, active, accept, push, pop;

  // Inverse of the control decoder's opcode/func map.
  always_comb begin
    enc_ok   = 1'b1;
    enc_word = '0;
    case (in_mnem)
      4'd0:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
      4'd1:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
      4'd2:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
      4'd3:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
      4'd4:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
      4'd5:  enc_word = {6'b100011, in_rs, in_rt, in_imm};
      4'd6:  enc_word = {6'b101011, in_rs, in_rt, in_imm};
      4'd7:  enc_word = {6'b000100, in_rs, in_rt, in_imm};
      4'd8:  enc_word = {6'b000010, in_target};
      4'd9:  enc_word = {6'b001000, in_rs, in_rt, in_imm};
      4'd10: enc_word = {6'b001100, in_rs, in_rt, in_imm};
      4'd11: enc_word = {6'b001101, in_rs, in_rt, in_imm};
      4'd12: enc_word = {6'b100000, in_rs, in_rt, 16'h0000};
      default: enc_ok = 1'b0;
    endcase
  end

  always_comb begin
    active     = (state_q == LOAD) || (state_q == DRAIN);
    in_ready   = (state_q == LOAD) && (cnt_q != FULL_CNT);
    imem_we    = active && (cnt_q != '0);
    imem_wdata = imem_we ? mem_q[rd_ptr_q] : '0;
    accept     = in_valid && in_ready;
    push       = accept && enc_ok;
    pop        = imem_we && imem_ready;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = enc_word;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    addr_d   = pop ? addr_q + AW'(4) : addr_q;
    wc_d     = pop ? wc_q + 16'd1 : wc_q;
    err_d    = err_q || (accept && !enc_ok);
    state_d  = state_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = BASE;
          wc_d    = '0;
          err_d   = 1'b0;
        end
      end
      LOAD:    if (accept && in_last) state_d = DRAIN;
      // Leave on the edge that retires the final word.
      DRAIN:   if (cnt_d == '0) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= BASE;
      wc_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wc_q     <= wc_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign imem_addr  = addr_q;
  assign word_count = wc_q;
  assign err        = err_q;
  assign busy       = active;
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// sessions scored against a queue-based reference model.
module tb_instr_encoder;

  logic        clk, rst, start, in_valid, in_last, imem_ready;
  logic [3:0]  in_mnem;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_ready, imem_we, busy, done, err;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] word_count;

  logic        start2, valid2;
  logic        in_ready2, we2, busy2, done2, err2;
  logic [3:0]  addr2;
  logic [31:0] wdata2;
  logic [15:0] wc2;

  instr_encoder #(.DEPTH(4), .AW(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_ready(imem_ready), .busy(busy), .done(done),
    .err(err), .word_count(word_count));

  instr_encoder #(.DEPTH(4), .AW(4), .BASE_ADDR(12)) dut_wrap (
    .clk(clk), .rst(rst), .start(start2), .in_valid(valid2), .in_ready(in_ready2),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(we2), .imem_addr(addr2),
    .imem_wdata(wdata2), .imem_ready(imem_ready), .busy(busy2), .done(done2),
    .err(err2), .word_count(wc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: session phase (0 idle, 1 load, 2 drain, 3 done) and word queue.
  int          st;
  logic [31:0] exp_q[$];
  int unsigned exp_addr, exp_wc;
  bit          exp_err;
  logic [31:0] log_d[$];
  logic [9:0]  log_a[$];

  function automatic logic [31:0] ref_enc(input int unsigned m, rs, rt, rd, imm, tgt);
    int unsigned op;
    case (m)
      0: return (rs << 21) | (rt << 16) | (rd << 11) | 32;
      1: return (rs << 21) | (rt << 16) | (rd << 11) | 34;
      2: return (rs << 21) | (rt << 16) | (rd << 11) | 36;
      3: return (rs << 21) | (rt << 16) | (rd << 11) | 37;
      4: return (rs << 21) | (rt << 16) | (rd << 11) | 42;
      8: return (2 << 26) | tgt;
      5: op = 35;
      6: op = 43;
      7: op = 4;
      9: op = 8;
      10: op = 12;
      11: op = 13;
      default: op = 32;
    endcase
    return (op << 26) | (rs << 21) | (rt << 16) | ((m == 12) ? 0 : imm);
  endfunction

  task automatic model_reset();
    st = 0; exp_q.delete(); exp_addr = 0; exp_wc = 0; exp_err = 0;
  endtask

  task automatic randomize_fields(input int unsigned m);
    in_mnem = 4'(m); in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
    in_imm = 16'($urandom); in_target = 26'($urandom);
  endtask

  // One clock cycle on the main DUT, scored against the model.
  task automatic step(input bit s, input bit v, input bit last, input bit rdy, output bit acc);
    bit pop;
    start = s; in_valid = v; in_last = last; imem_ready = rdy;
    @(negedge clk);
    checks++;
    if (in_ready !== (st == 1 && exp_q.size() < 4)) begin
      failures++; $display("FAIL in_ready got=%b exp=%b", in_ready, (st == 1 && exp_q.size() < 4));
    end
    checks++;
    if (imem_we !== (exp_q.size() != 0)) begin
      failures++; $display("FAIL imem_we got=%b exp=%b", imem_we, exp_q.size() != 0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      if (imem_wdata !== exp_q[0] || imem_addr !== 10'(exp_addr)) begin
        failures++;
        $display("FAIL write got=%h@%0d exp=%h@%0d", imem_wdata, imem_addr, exp_q[0], exp_addr);
      end
    end else if (imem_wdata !== 32'h0) begin
      failures++; $display("FAIL wdata_idle got=%h exp=0", imem_wdata);
    end
    checks++;
    if ({busy, done, err, word_count} !== {(st == 1 || st == 2), st == 3, exp_err, 16'(exp_wc)}) begin
      failures++;
      $display("FAIL status got=b%b d%b e%b wc%0d exp=b%b d%b e%b wc%0d", busy, done, err, word_count,
               (st == 1 || st == 2), st == 3, exp_err, exp_wc);
    end
    if (imem_we && imem_ready) begin
      log_d.push_back(imem_wdata); log_a.push_back(imem_addr);
    end
    acc = v && st == 1 && exp_q.size() < 4;
    pop = exp_q.size() != 0 && rdy;
    if (pop) begin
      void'(exp_q.pop_front());
      exp_addr = (exp_addr + 4) % 1024;
      exp_wc = (exp_wc + 1) % 65536;
    end
    case (st)
      0, 3: if (s) begin st = 1; exp_addr = 0; exp_wc = 0; exp_err = 0; end
      1: if (acc) begin
        if (in_mnem < 13) exp_q.push_back(ref_enc(in_mnem, in_rs, in_rt, in_rd, in_imm, in_target));
        else exp_err = 1;
        if (last) st = 2;
      end
      default: if (exp_q.size() == 0) st = 3;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic drain_to_done();
    bit a;
    for (int k = 0; k < 40 && st != 3; k++) step(0, 0, 0, 1, a);
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL drain_timeout got=%b exp=1", done); end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; in_valid = 0; in_last = 0; imem_ready = 0; start2 = 0; valid2 = 0;
    randomize_fields(0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
    checks++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, word_count} !== '0) begin
      failures++;
      $display("FAIL reset got=r%b we%b a%0d d%h b%b dn%b e%b wc%0d exp=all zero", in_ready, imem_we,
               imem_addr, imem_wdata, busy, done, err, word_count);
    end
  endtask

  task automatic test_add();
    bit a;
    log_d.delete(); log_a.delete();
    step(1, 0, 0, 1, a);
    checks++;
    if (busy !== 1 || in_ready !== 1) begin
      failures++; $display("FAIL start_busy got=%b%b exp=11", busy, in_ready);
    end
    in_mnem = 0; in_rs = 1; in_rt = 2; in_rd = 3;
    step(0, 1, 1, 1, a);
    checks++;
    if (imem_we !== 1 || imem_wdata !== 32'h00221820 || imem_addr !== 0) begin
      failures++; $display("FAIL add_word got=%b %h@%0d exp=1 00221820@0", imem_we, imem_wdata, imem_addr);
    end
    step(0, 0, 0, 1, a);
    checks++;
    if (done !== 1 || word_count !== 16'd1 || log_d.size() != 1) begin
      failures++; $display("FAIL add_done got=%b wc%0d n%0d exp=1 wc1 n1", done, word_count, log_d.size());
    end
  endtask

  task automatic test_lw_jmp();
    bit a;
    log_d.delete(); log_a.delete();
    step(1, 0, 0, 1, a);
    in_mnem = 5; in_rs = 4; in_rt = 5; in_imm = 16'hFFFC;
    step(0, 1, 0, 1, a);
    in_mnem = 8; in_target = 26'h10;
    step(0, 1, 1, 1, a);
    drain_to_done();
    checks++;
    if (log_d.size() != 2) begin
      failures++; $display("FAIL lwjmp_count got=%0d exp=2", log_d.size());
    end else if (log_d[0] !== 32'h8C85FFFC || log_a[0] !== 0 || log_d[1] !== 32'h08000010 ||
                 log_a[1] !== 4 || err !== 0) begin
      failures++;
      $display("FAIL lwjmp got=%h@%0d %h@%0d err%b exp=8c85fffc@0 08000010@4 err0",
               log_d[0], log_a[0], log_d[1], log_a[1], err);
    end
  endtask

  task automatic test_backpressure();
    bit a;
    int accepted = 0;
    log_d.delete(); log_a.delete();
    step(1, 0, 0, 0, a);
    for (int c = 0; c < 30 && accepted < 5; c++) begin
      randomize_fields(0);
      step(0, 1, accepted == 4, c >= 8, a);
      if (a) accepted++;
      if (c == 6) begin
        checks++;
        if (accepted != 4 || in_ready !== 0 || imem_we !== 1 || imem_addr !== 0) begin
          failures++;
          $display("FAIL full_stall got=acc%0d r%b we%b a%0d exp=acc4 r0 we1 a0", accepted, in_ready,
                   imem_we, imem_addr);
        end
      end
    end
    drain_to_done();
    checks++;
    if (log_a.size() != 5) begin
      failures++; $display("FAIL bp_count got=%0d exp=5", log_a.size());
    end else if (log_a[0] !== 0 || log_a[1] !== 4 || log_a[2] !== 8 || log_a[3] !== 12 || log_a[4] !== 16) begin
      failures++;
      $display("FAIL bp_addr got=%0d,%0d,%0d,%0d,%0d exp=0,4,8,12,16", log_a[0], log_a[1], log_a[2],
               log_a[3], log_a[4]);
    end
  endtask

  task automatic test_invalid();
    bit a;
    log_d.delete(); log_a.delete();
    step(1, 0, 0, 1, a);
    randomize_fields(0);
    step(0, 1, 0, 1, a);
    randomize_fields(14);
    step(0, 1, 0, 1, a);
    in_mnem = 11; in_rs = 0; in_rt = 1; in_imm = 16'h00FF;
    step(0, 1, 1, 1, a);
    drain_to_done();
    checks++;
    if (log_d.size() != 2 || err !== 1 || word_count !== 16'd2) begin
      failures++; $display("FAIL inv_status got=n%0d e%b wc%0d exp=n2 e1 wc2", log_d.size(), err, word_count);
    end else if (log_d[1] !== 32'h340100FF || log_a[1] !== 4) begin
      failures++; $display("FAIL ori_word got=%h@%0d exp=340100ff@4", log_d[1], log_a[1]);
    end
    // A session of nothing but invalid beats still completes, with no writes.
    log_d.delete();
    step(1, 0, 0, 1, a);
    randomize_fields(13);
    step(0, 1, 1, 1, a);
    drain_to_done();
    checks++;
    if (log_d.size() != 0 || err !== 1 || word_count !== 0) begin
      failures++; $display("FAIL all_invalid got=n%0d e%b wc%0d exp=n0 e1 wc0", log_d.size(), err, word_count);
    end
  endtask

  task automatic test_random();
    bit a;
    for (int s = 0; s < 6; s++) begin
      int beats = 0;
      step(1, 0, 0, 1, a);
      for (int c = 0; c < 200 && st == 1; c++) begin
        randomize_fields($urandom_range(0, 15));
        step(0, ($urandom % 4) != 0, beats >= 6 && ($urandom % 3) == 0, ($urandom % 3) != 0, a);
        if (a) beats++;
      end
      drain_to_done();
    end
  endtask

  task automatic test_wrap();
    logic [3:0] a2[$];
    int beats = 0;
    imem_ready = 1; in_last = 0; randomize_fields(0);
    start2 = 1; @(posedge clk); #1 start2 = 0; valid2 = 1;
    for (int c = 0; c < 20 && done2 !== 1; c++) begin
      @(negedge clk);
      if (we2) a2.push_back(addr2);
      if (valid2 && in_ready2) beats++;
      @(posedge clk); #1;
      if (beats >= 1) in_last = 1;
      if (beats >= 2) valid2 = 0;
    end
    checks++;
    if (a2.size() != 2 || done2 !== 1) begin
      failures++; $display("FAIL wrap_count got=n%0d d%b exp=n2 d1", a2.size(), done2);
    end else if (a2[0] !== 4'd12 || a2[1] !== 4'd0) begin
      failures++; $display("FAIL wrap_addr got=%0d,%0d exp=12,0", a2[0], a2[1]);
    end
    in_last = 0;
  endtask

  task automatic test_rst_drain();
    bit a;
    step(1, 0, 0, 0, a);
    for (int i = 0; i < 3; i++) begin
      randomize_fields($urandom_range(0, 12));
      step(0, 1, i == 2, 0, a);
    end
    checks++;
    if (busy !== 1 || in_ready !== 0 || imem_we !== 1) begin
      failures++; $display("FAIL drain_state got=b%b r%b we%b exp=b1 r0 we1", busy, in_ready, imem_we);
    end
    rst = 1; @(posedge clk); #1 rst = 0;
    model_reset();
    checks++;
    if (imem_we !== 0 || busy !== 0 || word_count !== 0 || done !== 0 || imem_addr !== 0) begin
      failures++;
      $display("FAIL rst_abort got=we%b b%b wc%0d d%b a%0d exp=0 0 0 0 0", imem_we, busy, word_count,
               done, imem_addr);
    end
    log_d.delete(); log_a.delete();
    step(1, 0, 0, 1, a);
    in_mnem = 7; in_rs = 1; in_rt = 2; in_imm = 16'd3;
    step(0, 1, 1, 1, a);
    drain_to_done();
    checks++;
    if (log_d.size() != 1) begin
      failures++; $display("FAIL beq_count got=%0d exp=1", log_d.size());
    end else if (log_d[0] !== 32'h10220003 || log_a[0] !== 0) begin
      failures++; $display("FAIL beq_word got=%h@%0d exp=10220003@0", log_d[0], log_a[0]);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_jmp();
    test_backpressure();
    test_invalid();
    test_random();
    test_wrap();
    test_rst_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder and instruction-memory writer for the single-cycle core. It accepts instructions as mnemonic IDs plus operand fields over a valid/ready handshake and packs them into 32-bit words. The packing is the exact inverse of the main control decoder's opcode/func map. Encoded words are buffered in a small FIFO and written to consecutive instruction-memory word addresses ahead of program execution.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- AW, 10, instruction-memory byte-address width
- BASE_ADDR, 0, first write address; multiple of 4
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  pulse; begins a load session
- in_valid  input  1  instruction fields valid
- in_ready  output  1  encoder accepts this cycle
- in_mnem  input  4  mnemonic ID (see Operation)
- in_rs, in_rt, in_rd  input  5 each  register fields
- in_imm  input  16  immediate (LW/SW/BEQ/ADDI/ANDI/ORI)
- in_target  input  26  jump target (JMP)
- in_last  input  1  final instruction of session
- imem_we  output  1  write request
- imem_addr  output  AW  byte address of current write
- imem_wdata  output  32  encoded word
- imem_ready  input  1  memory accepts write this cycle
- busy  output  1  state is LOAD or DRAIN
- done  output  1  state is DONE
- err  output  1  sticky: invalid mnemonic seen this session
- word_count  output  16  words written this session; wraps

## Operation
- Mnemonic encodings:
  - 0 ADD: {000000,rs,rt,rd,00000,100000}
  - 1 SUB: func 100010
  - 2 AND: func 100100
  - 3 OR: func 100101
  - 4 SLT: func 101010
  - 5 LW: {100011,rs,rt,imm}
  - 6 SW: {101011,rs,rt,imm}
  - 7 BEQ: {000100,rs,rt,imm}
  - 8 JMP: {000010,target}
  - 9 ADDI: {001000,rs,rt,imm}
  - 10 ANDI: {001100,rs,rt,imm}
  - 11 ORI: {001101,rs,rt,imm}
  - 12 RSWP: {100000,rs,rt,16'h0000}
  - 13–15: invalid
- Fields not used by a format are ignored.
- States:
  - IDLE: in_ready=0. start → LOAD; on entry imem_addr=BASE_ADDR, word_count=0, err=0.
  - LOAD: in_ready = !fifo_full. A handshake (in_valid&in_ready) with a valid mnemonic pushes the encoded word. An invalid mnemonic pushes nothing and sets err. An accepted beat with in_last=1 → DRAIN, whether that beat is valid or invalid.
  - DRAIN: in_ready=0. FIFO empty → DONE.
  - DONE: done=1. start → LOAD, with the same initialisation as leaving IDLE.
- start is ignored in LOAD and DRAIN.
- Write side (LOAD and DRAIN):
  - imem_we = !fifo_empty; imem_wdata = FIFO head.
  - When the FIFO is empty, imem_wdata=0.
  - On imem_we&imem_ready: pop, imem_addr += 4 (modulo 2^AW), word_count += 1.
- imem_we/imem_wdata/imem_addr hold stable while imem_ready=0.
- Push when full is blocked even if a pop occurs the same cycle. Push and pop in the same cycle when not full are both performed.

## Timing
- Reset values: in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, err=0, word_count=0. FIFO emptied; state IDLE.
- rst mid-session aborts the session: unwritten words are discarded, and outputs return to reset values on the next edge.
- start sampled at edge N → busy=1 and in_ready=1 from N+1.
- Latency: a word accepted at edge N appears on imem_we/imem_wdata from N+1. There is no combinational bypass.
- Throughput: one word per cycle when in_valid and imem_ready are held high.
- DRAIN → DONE on the edge after the final pop, so done=1 in the cycle after the last write handshake.
- Session with only invalid beats: LOAD → DRAIN → DONE with zero writes, err=1.

## Test plan
- start; ADD rs=1 rt=2 rd=3 last=1, imem_ready=1 → one write 0x00221820 @0, word_count=1, done=1 next cycle.
- LW rs=4 rt=5 imm=0xFFFC, then JMP target=0x10 last=1 → 0x8C85FFFC @0, 0x08000010 @4, err=0.
- imem_ready=0, offer 5 valid ADDs (DEPTH=4) → in_ready=0 after 4 accepted, imem outputs held. Release imem_ready → writes in order @0,4,8,12,16.
- ADD, mnem=14, ORI rs=0 rt=1 imm=0x00FF last=1 → err=1, two writes @0 (ADD) and @4 (0x340100FF), word_count=2.
- AW=4, BASE_ADDR=12: two words → addresses 12 then 0 (wrap).
- rst during DRAIN with 3 words buffered → next cycle imem_we=0, busy=0, word_count=0. New start + one BEQ rs=1 rt=2 imm=3 → 0x10220003 @BASE_ADDR.
